// File: rtl/reg_file_ba.sv
// reg_file_ba: DEPTH x WIDTH general-purpose register file with one
// synchronous write port and two registered read ports. Port A can be
// forced to read zero for R0 (base-address mode), and an optional
// write-to-read bypass makes a same-edge write visible to the reads.
module reg_file_ba #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  input  logic             BAout,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_valid
);

  // Every register must clear on clr, so storage is a register array
  // rather than a RAM macro.
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;
  logic             rd_valid_q;
  logic [WIDTH-1:0] rd_data_a_d, rd_data_b_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    // Per-register write decode; clr clears and drops any concurrent write.
    always_ff @(posedge clk) begin
      if (clr) begin
        regs_q[gi] <= '0;
      end else if (wr_en && (wr_addr == AW'(gi))) begin
        regs_q[gi] <= wr_data;
      end
    end
  end

  // Read-source selection: stored value, optionally the in-flight write,
  // with R0 zero-forcing on port A taking priority over the bypass.
  always_comb begin
    rd_data_a_d = regs_q[rd_addr_a];
    rd_data_b_d = regs_q[rd_addr_b];
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) begin
      rd_data_a_d = wr_data;
    end
    if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) begin
      rd_data_b_d = wr_data;
    end
    if (BAout && (rd_addr_a == '0)) begin
      rd_data_a_d = '0;
    end
  end

  // Read registers update only on an accepted read; rd_valid tracks rd_en.
  always_ff @(posedge clk) begin
    if (clr) begin
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_a_q <= rd_data_a_d;
        rd_data_b_q <= rd_data_b_d;
      end
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_reg_file_ba.sv
// Directed testbench for reg_file_ba: a default (BYPASS=1) and a BYPASS=0
// instance share stimulus; a WIDTH=8/DEPTH=4 instance covers the sweep.
module tb_reg_file_ba;

  logic        clk = 1'b0;
  logic        clr, wr_en, rd_en, BAout;
  logic [3:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data;
  logic [31:0] a1, b1, a0, b0;
  logic        v1, v0;

  logic        s_wr_en, s_rd_en, s_ba;
  logic [1:0]  s_wr_addr, s_rd_addr_a, s_rd_addr_b;
  logic [7:0]  s_wr_data, s_a, s_b;
  logic        s_v;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg_file_ba #(.WIDTH(32), .DEPTH(16), .BYPASS(1)) dut_byp (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .BAout(BAout),
    .rd_data_a(a1), .rd_data_b(b1), .rd_valid(v1));

  reg_file_ba #(.WIDTH(32), .DEPTH(16), .BYPASS(0)) dut_nobyp (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .BAout(BAout),
    .rd_data_a(a0), .rd_data_b(b0), .rd_valid(v0));

  reg_file_ba #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) dut_small (
    .clk(clk), .clr(clr), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .rd_en(s_rd_en), .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b), .BAout(s_ba),
    .rd_data_a(s_a), .rd_data_b(s_b), .rd_valid(s_v));

  // One clock on the shared 32-bit instances; outputs settle 1 ns after the edge.
  task automatic step(input logic c, input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic re, input logic [3:0] ra,
                      input logic [3:0] rb, input logic ba);
    clr = c; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr_a = ra; rd_addr_b = rb; BAout = ba;
    @(posedge clk); #1;
    $display("step clr=%0b we=%0b wa=%0d wd=%h re=%0b ra=%0d rb=%0d ba=%0b -> A=%h B=%h V=%0b | A0=%h B0=%h V0=%0b",
             c, we, wa, wd, re, ra, rb, ba, a1, b1, v1, a0, b0, v0);
  endtask

  task automatic step_s(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic re, input logic [1:0] ra, input logic [1:0] rb);
    s_wr_en = we; s_wr_addr = wa; s_wr_data = wd;
    s_rd_en = re; s_rd_addr_a = ra; s_rd_addr_b = rb; s_ba = 1'b0;
    @(posedge clk); #1;
    $display("small we=%0b wa=%0d wd=%h re=%0b ra=%0d rb=%0d -> A=%h B=%h V=%0b",
             we, wa, wd, re, ra, rb, s_a, s_b, s_v);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'd0 || v1 !== 1'b0) begin
      miscompares++; $display("FAIL reset_state: A=%h B=%h V=%0b expected 0 0 0", a1, b1, v1); end
    step(0, 1, 3, 32'hDEAD_BEEF, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 3, 0);
    vectors++; if (a1 !== 32'hDEAD_BEEF || v1 !== 1'b1) begin
      miscompares++; $display("FAIL preload_r3: A=%h V=%0b expected deadbeef 1", a1, v1); end
    step(1, 1, 3, 32'h1234_5678, 1, 3, 3, 0);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'd0 || v1 !== 1'b0) begin
      miscompares++; $display("FAIL clr_outputs: A=%h B=%h V=%0b expected 0 0 0", a1, b1, v1); end
    step(0, 0, 0, 0, 1, 3, 3, 0);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'd0 || v1 !== 1'b1) begin
      miscompares++; $display("FAIL clr_r3_cleared: A=%h B=%h V=%0b expected 0 0 1", a1, b1, v1); end
  endtask

  task automatic test_write_read;
    step(0, 1, 5, 32'd10, 0, 0, 0, 0);
    vectors++; if (v1 !== 1'b0) begin
      miscompares++; $display("FAIL valid_no_read: V=%0b expected 0", v1); end
    step(0, 0, 0, 0, 1, 5, 5, 0);
    vectors++; if (a1 !== 32'd10 || b1 !== 32'd10 || v1 !== 1'b1) begin
      miscompares++; $display("FAIL read_r5: A=%h B=%h V=%0b expected a a 1", a1, b1, v1); end
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0, 0, 0, 1, 2, 0);
      vectors++; if (a1 !== 32'd10 || b1 !== 32'd10 || v1 !== 1'b0) begin
        miscompares++; $display("FAIL hold_%0d: A=%h B=%h V=%0b expected a a 0", i, a1, b1, v1); end
    end
  endtask

  task automatic test_base_addr;
    step(0, 1, 0, 32'd20, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 1);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'd20) begin
      miscompares++; $display("FAIL ba_on: A=%h B=%h expected 0 14", a1, b1); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    vectors++; if (a1 !== 32'd20 || b1 !== 32'd20) begin
      miscompares++; $display("FAIL ba_off: A=%h B=%h expected 14 14", a1, b1); end
    step(0, 0, 0, 0, 0, 0, 0, 1);
    vectors++; if (a1 !== 32'd20 || v1 !== 1'b0) begin
      miscompares++; $display("FAIL ba_no_read: A=%h V=%0b expected 14 0", a1, v1); end
    step(0, 0, 0, 0, 1, 0, 0, 1);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'd20) begin
      miscompares++; $display("FAIL ba_again: A=%h B=%h expected 0 14", a1, b1); end
    step(0, 0, 0, 0, 1, 5, 0, 1);
    vectors++; if (a1 !== 32'd10 || b1 !== 32'd20) begin
      miscompares++; $display("FAIL ba_nonzero_a: A=%h B=%h expected a 14", a1, b1); end
  endtask

  task automatic test_bypass;
    step(0, 1, 7, 32'd1, 0, 0, 0, 0);
    step(0, 1, 7, 32'h55, 1, 7, 7, 0);
    vectors++; if (a1 !== 32'h55 || b1 !== 32'h55) begin
      miscompares++; $display("FAIL bypass_on: A=%h B=%h expected 55 55", a1, b1); end
    vectors++; if (a0 !== 32'd1 || b0 !== 32'd1) begin
      miscompares++; $display("FAIL bypass_off: A=%h B=%h expected 1 1", a0, b0); end
    step(0, 0, 0, 0, 1, 7, 5, 0);
    vectors++; if (a1 !== 32'h55 || a0 !== 32'h55 || b0 !== 32'd10) begin
      miscompares++; $display("FAIL after_write: A=%h A0=%h B0=%h expected 55 55 a", a1, a0, b0); end
  endtask

  task automatic test_bypass_ba;
    step(0, 1, 0, 32'h99, 1, 0, 0, 1);
    vectors++; if (a1 !== 32'd0 || b1 !== 32'h99) begin
      miscompares++; $display("FAIL bypass_ba: A=%h B=%h expected 0 99", a1, b1); end
    vectors++; if (a0 !== 32'd0 || b0 !== 32'd20) begin
      miscompares++; $display("FAIL nobypass_ba: A=%h B=%h expected 0 14", a0, b0); end
    step(0, 0, 0, 0, 1, 0, 0, 0);
    vectors++; if (a1 !== 32'h99 || a0 !== 32'h99) begin
      miscompares++; $display("FAIL r0_stored: A=%h A0=%h expected 99 99", a1, a0); end
  endtask

  task automatic test_sweep;
    for (int i = 0; i < 4; i++) step_s(1, 2'(i), 8'hA0 + 8'(i), 0, 0, 0);
    step_s(0, 0, 0, 1, 0, 1);
    vectors++; if (s_a !== 8'hA0 || s_b !== 8'hA1 || s_v !== 1'b1) begin
      miscompares++; $display("FAIL sweep_r01: A=%h B=%h V=%0b expected a0 a1 1", s_a, s_b, s_v); end
    step_s(0, 0, 0, 1, 2, 3);
    vectors++; if (s_a !== 8'hA2 || s_b !== 8'hA3) begin
      miscompares++; $display("FAIL sweep_r23: A=%h B=%h expected a2 a3", s_a, s_b); end
    step_s(1, 3, 8'hFF, 0, 0, 0);
    step_s(0, 0, 0, 1, 0, 1);
    vectors++; if (s_a !== 8'hA0 || s_b !== 8'hA1) begin
      miscompares++; $display("FAIL sweep_r01_after: A=%h B=%h expected a0 a1", s_a, s_b); end
    step_s(0, 0, 0, 1, 2, 3);
    vectors++; if (s_a !== 8'hA2 || s_b !== 8'hFF) begin
      miscompares++; $display("FAIL sweep_r23_after: A=%h B=%h expected a2 ff", s_a, s_b); end
  endtask

  initial begin
    s_wr_en = 0; s_wr_addr = 0; s_wr_data = 0; s_rd_en = 0;
    s_rd_addr_a = 0; s_rd_addr_b = 0; s_ba = 0;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_write_read();
    test_base_addr();
    test_bypass();
    test_bypass_ba();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
